reg_scoreboard: RTL

Tracks in-flight register writes and throttles issue in the in-order RISC-V pipeline. The forwarding unit resolves hazards from the reader side by comparing source registers against pipeline-register destinations. This block is the writer side: at decode it records every accepted instruction's destination register and result latency, counts each result down to writeback, and asserts `stall` whenever a source operand cannot yet be supplied by forwarding. It sits beside the ID stage and drives the IF/ID hold and ID/EX bubble insertion.

---
 rtl/reg_scoreboard.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: writer-side register scoreboard for the in-order pipeline.
// Records the destination and result latency of every accepted instruction,
// counts each pending result down to writeback, and raises stall when a
// source operand cannot yet be forwarded or when a younger write would
// retire ahead of an older, longer-latency write to the same register.
// A one-deep undo record lets a flush retract the most recent issue.
// Optional feature macro: SCOREBOARD_PERF_EN (adds stall_cycles/waw_cycles).
//
// Handshake: an instruction is accepted on a rising edge where
// issue_valid=1, stall=0 and flush=0; nothing else changes scoreboard
// ownership. stall is combinational from current state and inputs.
module reg_scoreboard #(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int WB_TAIL  = 2,
  parameter int CNT_W    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_regWrite,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_lat,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic        early_read,
  input  logic        flush,
  output logic        stall,
  output logic        waw_stall,
  output logic [31:0] busy_mask
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] waw_cycles
`endif
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Counter load values: latency of the class plus the forwardable tail.
  localparam logic [CNT_W-1:0] LD_ALU  = CNT_W'(ALU_LAT + WB_TAIL);
  localparam logic [CNT_W-1:0] LD_LOAD = CNT_W'(LOAD_LAT + WB_TAIL);
  localparam logic [CNT_W-1:0] LD_MUL  = CNT_W'(MUL_LAT + WB_TAIL);

  // RAW limits: a normal reader can take the value from EX/MEM or MEM/WB,
  // an early (ID-stage) reader needs it one cycle further along.
  localparam logic [31:0] RAW_LIM_N = 32'(WB_TAIL + 1);
  localparam logic [31:0] RAW_LIM_E = 32'(WB_TAIL);

  // Elaboration guard: every load value must fit in the counter.
  if ((ALU_LAT + WB_TAIL) > CNT_MAX || (LOAD_LAT + WB_TAIL) > CNT_MAX ||
      (MUL_LAT + WB_TAIL) > CNT_MAX) begin : g_cnt_w_check
    $error("reg_scoreboard: CNT_W too narrow for latency + WB_TAIL");
  end

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_cnt [32];

  logic             r_undo_vld;
  logic             r_undo_wr;
  logic [4:0]       r_undo_rd;
  logic             r_undo_busy;
  logic [CNT_W-1:0] r_undo_cnt;

  logic [CNT_W-1:0] w_new_cnt;
  logic [31:0]      w_raw_lim;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_waw;
  logic             w_stall;
  logic             w_accept;
  logic             w_load;
  logic             w_flush_wr;

  // Hazard detection and accept decision from current state and ID inputs.
  always_comb begin
    w_new_cnt = LD_ALU;
    case (issue_lat)
      2'b00:   w_new_cnt = LD_ALU;
      2'b01:   w_new_cnt = LD_LOAD;
      default: w_new_cnt = LD_MUL;
    endcase

    w_raw_lim = early_read ? RAW_LIM_E : RAW_LIM_N;

    w_raw1 = rs1_used && (IF_ID_rs1 != 5'd0) && r_busy[IF_ID_rs1] &&
             (32'(r_cnt[IF_ID_rs1]) > w_raw_lim);
    w_raw2 = rs2_used && (IF_ID_rs2 != 5'd0) && r_busy[IF_ID_rs2] &&
             (32'(r_cnt[IF_ID_rs2]) > w_raw_lim);

    // A younger write may not finish before an older pending one.
    w_waw = issue_valid && issue_regWrite && (issue_rd != 5'd0) &&
            r_busy[issue_rd] && (r_cnt[issue_rd] > w_new_cnt);

    w_stall    = issue_valid && (w_raw1 || w_raw2 || w_waw);
    w_accept   = issue_valid && !w_stall && !flush;
    w_load     = w_accept && issue_regWrite && (issue_rd != 5'd0);
    w_flush_wr = flush && r_undo_vld && r_undo_wr;
  end

  assign stall     = w_stall;
  assign waw_stall = w_waw;
  assign busy_mask = r_busy;

  // Per-register entries: issue reload wins, then flush restore, else count down.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_busy <= '0;
      for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (w_load && (issue_rd == 5'(r))) begin
          r_busy[r] <= 1'b1;
          r_cnt[r]  <= w_new_cnt;
        end else if (w_flush_wr && (r_undo_rd == 5'(r))) begin
          if (r_undo_busy && (r_undo_cnt > CNT_W'(1))) begin
            r_busy[r] <= 1'b1;
            r_cnt[r]  <= r_undo_cnt - CNT_W'(1);
          end else begin
            r_busy[r] <= 1'b0;
            r_cnt[r]  <= '0;
          end
        end else if (r_busy[r] && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
          if (r_cnt[r] == CNT_W'(1)) r_busy[r] <= 1'b0;
        end
      end
    end
  end

  // Undo record: valid only in the cycle right after an accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_undo_vld  <= 1'b0;
      r_undo_wr   <= 1'b0;
      r_undo_rd   <= '0;
      r_undo_busy <= 1'b0;
      r_undo_cnt  <= '0;
    end else begin
      r_undo_vld <= w_accept;
      if (w_accept) begin
        r_undo_rd   <= issue_rd;
        r_undo_wr   <= issue_regWrite && (issue_rd != 5'd0);
        r_undo_busy <= r_busy[issue_rd];
        r_undo_cnt  <= r_cnt[issue_rd];
      end
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_waw_cycles;

  // Free-running stall statistics, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_waw_cycles   <= '0;
    end else begin
      if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_waw)   r_waw_cycles   <= r_waw_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign waw_cycles   = r_waw_cycles;
`endif

endmodule
